fmul_initiator: RTL and testbench

- Initiator side of the stb/ack handshake used by the `multiplier` block.
- Accepts one operand pair per `start` pulse from local control logic (switch/FSM front end).
- Drives the multiplier's A and B input channels, collects `output_z`, and presents a registered result with a `done` pulse.
- Provides timeout detection and a transaction counter for board-level debug.

---
 rtl/fmul_initiator.sv | 155 +++++++++++++++
 tb/tb_fmul_initiator.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_initiator.sv
// fmul_initiator: initiator side of the stb/ack handshake into the floating
// point multiplier. It captures one operand pair per start pulse, strobes the
// A and B channels independently and waits for output_z. It then presents the
// product with a one-cycle done pulse. A per-phase watchdog aborts a stalled
// handshake and raises a sticky timeout flag. A wrapping counter tracks
// completed transactions for board-level debug.
module fmul_initiator #(
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    output logic             busy,
    output logic             done,
    output logic [31:0]      result,
    output logic             timeout_err,
    output logic [CNT_W-1:0] txn_count,
    output logic [31:0]      mult_a,
    output logic             mult_a_stb,
    input  logic             mult_a_ack,
    output logic [31:0]      mult_b,
    output logic             mult_b_stb,
    input  logic             mult_b_ack,
    input  logic [31:0]      mult_z,
    input  logic             mult_z_stb,
    output logic             mult_z_ack
);

    // The phase timer only needs to count up to TIMEOUT-1.
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RECV = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;

    logic a_xfer;
    logic b_xfer;
    logic a_left;
    logic b_left;
    logic send_complete;
    logic z_xfer;
    logic timer_expired;

    // Decode this cycle's transfers and whether the operand phase finishes now.
    always_comb begin
        a_xfer        = mult_a_stb & mult_a_ack;
        b_xfer        = mult_b_stb & mult_b_ack;
        a_left        = mult_a_stb & ~mult_a_ack;
        b_left        = mult_b_stb & ~mult_b_ack;
        send_complete = ~a_left & ~b_left;
        z_xfer        = mult_z_stb & mult_z_ack;
        timer_expired = (timer == TIMER_LAST);
    end

    // Handshake sequencer with fully registered outputs. Each strobe drops on
    // the same edge as its transfer. On timeout every strobe drops and the
    // block returns to IDLE without touching result or txn_count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            timer       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            timeout_err <= 1'b0;
            txn_count   <= '0;
            mult_a      <= '0;
            mult_a_stb  <= 1'b0;
            mult_b      <= '0;
            mult_b_stb  <= 1'b0;
            mult_z_ack  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mult_a      <= op_a;
                        mult_b      <= op_b;
                        mult_a_stb  <= 1'b1;
                        mult_b_stb  <= 1'b1;
                        timeout_err <= 1'b0;
                        timer       <= '0;
                        busy        <= 1'b1;
                        state       <= SEND;
                    end
                end
                SEND: begin
                    if (a_xfer) begin
                        mult_a_stb <= 1'b0;
                    end
                    if (b_xfer) begin
                        mult_b_stb <= 1'b0;
                    end
                    if (send_complete) begin
                        mult_z_ack <= 1'b1;
                        timer      <= '0;
                        state      <= RECV;
                    end else if (timer_expired) begin
                        mult_a_stb  <= 1'b0;
                        mult_b_stb  <= 1'b0;
                        mult_z_ack  <= 1'b0;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        timer       <= '0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RECV: begin
                    if (z_xfer) begin
                        result     <= mult_z;
                        mult_z_ack <= 1'b0;
                        txn_count  <= txn_count + CNT_W'(1);
                        done       <= 1'b1;
                        timer      <= '0;
                        state      <= DONE;
                    end else if (timer_expired) begin
                        mult_a_stb  <= 1'b0;
                        mult_b_stb  <= 1'b0;
                        mult_z_ack  <= 1'b0;
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        timer       <= '0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    mult_a_stb <= 1'b0;
                    mult_b_stb <= 1'b0;
                    mult_z_ack <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fmul_initiator.sv
// tb_fmul_initiator: directed bench for fmul_initiator. The multiplier side
// is driven straight from the stimulus sequence. Expected values are written
// out by hand.
module tb_fmul_initiator;

    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             busy;
    logic             done;
    logic [31:0]      result;
    logic             timeout_err;
    logic [CNT_W-1:0] txn_count;
    logic [31:0]      mult_a;
    logic             mult_a_stb;
    logic             mult_a_ack;
    logic [31:0]      mult_b;
    logic             mult_b_stb;
    logic             mult_b_ack;
    logic [31:0]      mult_z;
    logic             mult_z_stb;
    logic             mult_z_ack;

    int total;
    int bad;
    int done_seen;
    int done_mark;

    fmul_initiator #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .timeout_err(timeout_err),
        .txn_count  (txn_count),
        .mult_a     (mult_a),
        .mult_a_stb (mult_a_stb),
        .mult_a_ack (mult_a_ack),
        .mult_b     (mult_b),
        .mult_b_stb (mult_b_stb),
        .mult_b_ack (mult_b_ack),
        .mult_z     (mult_z),
        .mult_z_stb (mult_z_stb),
        .mult_z_ack (mult_z_ack)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count every done pulse so that extra or missing pulses are visible.
    initial done_seen = 0;
    always @(negedge clk) begin
        if (done === 1'b1) done_seen++;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b0;
        start      = 1'b0;
        op_a       = '0;
        op_b       = '0;
        mult_a_ack = 1'b0;
        mult_b_ack = 1'b0;
        mult_z     = '0;
        mult_z_stb = 1'b0;

        // Reset state
        #3;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_txn", 32'(txn_count), 32'd0);
        checkOutput("rst_terr", 32'(timeout_err), 32'd0);
        checkOutput("rst_stbs", {29'd0, mult_a_stb, mult_b_stb, mult_z_ack}, 32'd0);
        checkOutput("rst_mult_a", mult_a, 32'd0);
        #9 rst = 1'b1;
        stepClock();

        // Test 1: 1.0 x 1.0, multiplier ready everywhere
        $display("[TB] test 1: minimum-latency transaction");
        mult_a_ack = 1'b1;
        mult_b_ack = 1'b1;
        mult_z_stb = 1'b1;
        mult_z     = 32'h3F80_0000;
        op_a       = 32'h3F80_0000;
        op_b       = 32'h3F80_0000;
        start      = 1'b1;
        done_mark  = done_seen;
        stepClock();
        start = 1'b0;
        checkOutput("t1_send_stbs", {30'd0, mult_a_stb, mult_b_stb}, 32'd3);
        checkOutput("t1_send_busy", 32'(busy), 32'd1);
        checkOutput("t1_mult_a", mult_a, 32'h3F80_0000);
        checkOutput("t1_mult_b", mult_b, 32'h3F80_0000);
        stepClock();
        checkOutput("t1_recv_stbs", {29'd0, mult_a_stb, mult_b_stb, mult_z_ack}, 32'd1);
        stepClock();
        checkOutput("t1_done", 32'(done), 32'd1);
        checkOutput("t1_result", result, 32'h3F80_0000);
        checkOutput("t1_txn", 32'(txn_count), 32'd1);
        checkOutput("t1_zack_drop", 32'(mult_z_ack), 32'd0);
        checkOutput("t1_done_busy", 32'(busy), 32'd1);
        stepClock();
        checkOutput("t1_done_gone", 32'(done), 32'd0);
        checkOutput("t1_idle_busy", 32'(busy), 32'd0);
        checkOutput("t1_pulses", 32'(done_seen - done_mark), 32'd1);

        // Test 2: 2.0 x 3.0 with B acknowledged five cycles after A
        $display("[TB] test 2: staggered operand acks");
        mult_a_ack = 1'b1;
        mult_b_ack = 1'b0;
        mult_z_stb = 1'b0;
        op_a       = 32'h4000_0000;
        op_b       = 32'h4040_0000;
        start      = 1'b1;
        stepClock();
        start = 1'b0;
        op_a  = 32'hDEAD_BEEF;
        op_b  = 32'hCAFE_F00D;
        checkOutput("t2_send_stbs", {30'd0, mult_a_stb, mult_b_stb}, 32'd3);
        stepClock();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_a_dropped", 32'(mult_a_stb), 32'd0);
            checkOutput("t2_b_held", 32'(mult_b_stb), 32'd1);
            checkOutput("t2_b_stable", mult_b, 32'h4040_0000);
            if (i < 4) stepClock();
        end
        mult_b_ack = 1'b1;
        stepClock();
        checkOutput("t2_recv_stbs", {29'd0, mult_a_stb, mult_b_stb, mult_z_ack}, 32'd1);
        stepClock();
        stepClock();
        mult_z     = 32'h40C0_0000;
        mult_z_stb = 1'b1;
        stepClock();
        checkOutput("t2_done", 32'(done), 32'd1);
        checkOutput("t2_result", result, 32'h40C0_0000);
        checkOutput("t2_txn", 32'(txn_count), 32'd2);
        stepClock();

        // Test 3: z never arrives, RECV phase times out
        $display("[TB] test 3: receive timeout");
        mult_z_stb = 1'b0;
        op_a       = 32'h3F80_0000;
        op_b       = 32'h4080_0000;
        start      = 1'b1;
        done_mark  = done_seen;
        stepClock();
        start = 1'b0;
        stepClock();
        checkOutput("t3_recv_zack", 32'(mult_z_ack), 32'd1);
        repeat (TIMEOUT - 1) stepClock();
        checkOutput("t3_still_waiting", {30'd0, busy, mult_z_ack}, 32'd3);
        stepClock();
        checkOutput("t3_terr", 32'(timeout_err), 32'd1);
        checkOutput("t3_busy", 32'(busy), 32'd0);
        checkOutput("t3_stbs", {29'd0, mult_a_stb, mult_b_stb, mult_z_ack}, 32'd0);
        checkOutput("t3_txn", 32'(txn_count), 32'd2);
        checkOutput("t3_result", result, 32'h40C0_0000);
        checkOutput("t3_no_done", 32'(done_seen - done_mark), 32'd0);
        stepClock();
        checkOutput("t3_terr_sticky", 32'(timeout_err), 32'd1);
        mult_z     = 32'h4080_0000;
        mult_z_stb = 1'b1;
        start      = 1'b1;
        stepClock();
        start = 1'b0;
        checkOutput("t3_terr_cleared", 32'(timeout_err), 32'd0);
        stepClock();
        stepClock();
        checkOutput("t3_retry_result", result, 32'h4080_0000);
        checkOutput("t3_retry_txn", 32'(txn_count), 32'd3);
        stepClock();

        // Test 4: start pulses during SEND and RECV are ignored
        $display("[TB] test 4: start while busy");
        mult_a_ack = 1'b0;
        mult_b_ack = 1'b0;
        mult_z_stb = 1'b0;
        mult_z     = 32'h4040_0000;
        op_a       = 32'h3FC0_0000;
        op_b       = 32'h4000_0000;
        start      = 1'b1;
        done_mark  = done_seen;
        stepClock();
        op_a = 32'h1234_5678;
        op_b = 32'h8765_4321;
        stepClock();
        start = 1'b0;
        checkOutput("t4_send_a_kept", mult_a, 32'h3FC0_0000);
        checkOutput("t4_send_b_kept", mult_b, 32'h4000_0000);
        mult_a_ack = 1'b1;
        mult_b_ack = 1'b1;
        stepClock();
        start = 1'b1;
        stepClock();
        start = 1'b0;
        checkOutput("t4_recv_held", {30'd0, busy, mult_z_ack}, 32'd3);
        checkOutput("t4_recv_a_kept", mult_a, 32'h3FC0_0000);
        checkOutput("t4_recv_no_stb", {30'd0, mult_a_stb, mult_b_stb}, 32'd0);
        mult_z_stb = 1'b1;
        stepClock();
        checkOutput("t4_result", result, 32'h4040_0000);
        stepClock();
        stepClock();
        checkOutput("t4_idle", 32'(busy), 32'd0);
        checkOutput("t4_one_done", 32'(done_seen - done_mark), 32'd1);
        checkOutput("t4_txn", 32'(txn_count), 32'd4);

        // Test 5: asynchronous reset in the middle of RECV
        $display("[TB] test 5: async reset mid-receive");
        mult_z_stb = 1'b0;
        start      = 1'b1;
        stepClock();
        start = 1'b0;
        stepClock();
        stepClock();
        checkOutput("t5_in_recv", 32'(mult_z_ack), 32'd1);
        #3 rst = 1'b0;
        #1;
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_stbs", {29'd0, mult_a_stb, mult_b_stb, mult_z_ack}, 32'd0);
        checkOutput("t5_result", result, 32'd0);
        checkOutput("t5_txn", 32'(txn_count), 32'd0);
        checkOutput("t5_mult_a", mult_a, 32'd0);
        checkOutput("t5_mult_b", mult_b, 32'd0);
        #2 rst = 1'b1;

        // Test 6: 17 back-to-back transactions wrap the 4-bit counter to 1
        $display("[TB] test 6: back-to-back wrap");
        mult_a_ack = 1'b1;
        mult_b_ack = 1'b1;
        mult_z_stb = 1'b1;
        start      = 1'b1;
        done_mark  = done_seen;
        for (int i = 0; i < 17; i++) begin
            mult_z = 32'h4000_0000 + 32'(i);
            stepClock();
            checkOutput("t6_accept", 32'(busy), 32'd1);
            stepClock();
            stepClock();
            checkOutput("t6_done", 32'(done), 32'd1);
            checkOutput("t6_result", result, 32'h4000_0000 + 32'(i));
            checkOutput("t6_txn", 32'(txn_count), 32'((i + 1) % 16));
            stepClock();
            checkOutput("t6_idle", 32'(busy), 32'd0);
        end
        start = 1'b0;
        checkOutput("t6_wrapped", 32'(txn_count), 32'd1);
        checkOutput("t6_pulses", 32'(done_seen - done_mark), 32'd17);
        stepClock();
        checkOutput("t6_quiet", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
